// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive path
// Contents: state_t word-alignment states, CH_LEFT/CH_RIGHT lrck levels.
package i2s_pkg;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        RIGHT_SKIP = 2'd1,
        LEFT       = 2'd2,
        RIGHT      = 2'd3
    } state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_edge_sync.sv
// rtl/i2s_edge_sync.sv - N-stage synchroniser with per-bit rise detector
// Ports: clk, rst_n (sync active-low), din[W] async inputs,
//        sync[W] synchronised copy, rise[W] one-clk pulse on a synchronised 0->1.
module i2s_edge_sync #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise
);

    logic [N-1:0][W-1:0] chain;
    logic [W-1:0]        prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[N-2:0], din};
            prev  <= chain[N-1];
        end
    end

    assign sync = chain[N-1];
    assign rise = chain[N-1] & ~prev;

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S receive deserialiser producing stereo sample pairs
// Ports: clk, rst_n (sync active-low); bck, lrck, sdata serial link inputs;
//        out_left/out_right/out_valid/out_ready pair handshake;
//        overflow, frame_err sticky flags; clr_flags clears both.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int MAX_SLOT    = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bck,
    input  logic                lrck,
    input  logic                sdata,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow,
    output logic                frame_err,
    input  logic                clr_flags
);

    localparam int CNT_W = $clog2(MAX_SLOT + 1);
    localparam int POS_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    logic                bck_s;
    logic                bck_rise;
    logic [1:0]          data_s;
    logic [1:0]          data_rise;
    logic                lrck_s;
    logic                sdata_s;

    logic [SAMPLE_W-1:0] sreg;
    logic [SAMPLE_W-1:0] word_now;
    logic [SAMPLE_W-1:0] left_hold;
    logic [SAMPLE_W-1:0] right_word;
    logic [CNT_W-1:0]    bit_cnt;
    logic [POS_W-1:0]    bit_pos;
    logic                lrck_q;
    logic                lr_edge;
    logic                pair_done;
    state_t              state;

    i2s_edge_sync #(.N(SYNC_STAGES), .W(1)) u_bck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bck),
        .sync (bck_s),
        .rise (bck_rise)
    );

    // Same depth as the bck chain so data and word select stay aligned to bck_rise.
    i2s_edge_sync #(.N(SYNC_STAGES), .W(2)) u_data_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({sdata, lrck}),
        .sync (data_s),
        .rise (data_rise)
    );

    assign lrck_s  = data_s[0];
    assign sdata_s = data_s[1];
    assign lr_edge = (lrck_s != lrck_q);

    logic unused_ok;
    assign unused_ok = &{1'b0, bck_s, data_rise};

    // Word including the bit sampled on this rise; bits past SAMPLE_W are dropped.
    always_comb begin
        word_now = sreg;
        bit_pos  = POS_W'(SAMPLE_W - 1 - int'(bit_cnt));
        if (bit_cnt < CNT_W'(SAMPLE_W)) begin
            word_now[bit_pos] = sdata_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            lrck_q     <= 1'b0;
            state      <= HUNT;
            left_hold  <= '0;
            right_word <= '0;
            pair_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pair_done <= 1'b0;
            if (clr_flags) begin
                frame_err <= 1'b0;
            end
            if (bck_rise) begin
                lrck_q <= lrck_s;
                if (lr_edge) begin
                    // The bit on the edge rise is the LSB slot of the word just ending.
                    sreg    <= '0;
                    bit_cnt <= '0;
                    case (state)
                        HUNT: begin
                            if (lrck_s == CH_LEFT) begin
                                state <= LEFT;
                            end else if (lrck_s == CH_RIGHT) begin
                                state <= RIGHT_SKIP;
                            end
                        end
                        RIGHT_SKIP: state <= LEFT;
                        LEFT: begin
                            left_hold <= word_now;
                            state     <= RIGHT;
                        end
                        RIGHT: begin
                            right_word <= word_now;
                            pair_done  <= 1'b1;
                            state      <= LEFT;
                        end
                        default: state <= HUNT;
                    endcase
                end else begin
                    sreg <= word_now;
                    if (bit_cnt < CNT_W'(MAX_SLOT)) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(MAX_SLOT - 1)) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end
                end
            end
        end
    end

    // Output holding register: a pair arriving while the previous one is
    // still held and not being taken this cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (pair_done) begin
                if (!out_valid || out_ready) begin
                    out_left  <= left_hold;
                    out_right <= right_word;
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
